code_writer: RTL and testbench
==============================

CODE_WRITER -- requirements
Module: code_writer

Interface
REQ-001 Parameter: ADR_W, default 10, output code memory word-address width.
REQ-002 Parameter: DEPTH, default 4, packed-word FIFO depth (power of two, >=2).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low; one clock, and reset is synchronous and active-low.
REQ-005 in_valid  in  1  emitted ARM code byte present on in_byte.
REQ-006 in_byte  in  8  ARM code byte, little-endian order within a word.
REQ-007 flush  in  1  close the current partial word (end of translated JVM instruction block).
REQ-008 base_load  in  1  load base_adr into the write address.
REQ-009 base_adr  in  ADR_W  new start word address.
REQ-010 mem_ack  in  1  code memory accepts wr_data this cycle.
REQ-011 wr_en  out  1  write request to code memory.
REQ-012 wr_adr  out  ADR_W  word address of the current write.
REQ-013 wr_data  out  32  packed ARM instruction word.
REQ-014 waiting  out  1  back-pressure to the translating state machine; bytes and flush are not accepted while high.
REQ-015 busy  out  1  partial word held or FIFO non-empty.
REQ-016 word_count  out  16  words written since reset; wraps at 2^16.

Function
REQ-017 A byte is accepted on an edge with in_valid=1 and waiting=0; it is placed in lane byte_cnt (bits 8k+7:8k) and byte_cnt increments mod 4.
REQ-018 On acceptance of the lane-3 byte, the completed word is pushed into the FIFO on the same edge; there is no extra latency.
REQ-019 waiting = (FIFO count == DEPTH), driven from registered count only, with no combinational path from in_valid or mem_ack.
REQ-020 flush is accepted with waiting=0. If byte_cnt!=0, unfilled lanes are padded with 0x00, the word is pushed, and byte_cnt becomes 0. If byte_cnt==0, flush does nothing.
REQ-021 Byte and flush on the same edge: the byte is packed first, then the flush applies to the result. A byte that completes the word makes the flush a no-op, and exactly one word is pushed.
REQ-022 Write FSM W_IDLE/W_REQ: W_IDLE->W_REQ when the FIFO is non-empty. In W_REQ, wr_en=1, wr_data=FIFO head, and wr_adr=address register. wr_data and wr_adr stay stable until mem_ack.
REQ-023 W_REQ with mem_ack=1: pop head, wr_adr+1 mod 2^ADR_W, word_count+1. Stay in W_REQ if entries remain, otherwise return to W_IDLE. The next word may be presented the following cycle, giving 1 word/cycle throughput.
REQ-024 mem_ack while wr_en=0 is ignored.
REQ-025 Simultaneous push and pop: count is unchanged and ordering is preserved (FIFO strict in-order).
REQ-026 base_load is honoured only when busy=0, loading wr_adr on that edge; otherwise it is ignored entirely.
REQ-027 wr_adr wraps from 2^ADR_W-1 to 0 with no flag.
REQ-028 busy = (byte_cnt!=0) | (FIFO count!=0), registered-state based.

Reset
REQ-029 On an edge with reset=0: byte_cnt=0, FIFO empty, FSM=W_IDLE, wr_en=0, wr_adr=0, wr_data=0, word_count=0, waiting=0, busy=0.
REQ-030 Reset mid-operation discards any partial word and all FIFO contents, and deasserts wr_en after that edge, even when a write is pending without mem_ack.
REQ-031 Reset has priority over all other inputs on the same edge.

Verification
REQ-032 Pack: base_load with base_adr=0x010; bytes 0x01,0x02,0x03,0x04; mem_ack=1 -> wr_en the cycle after byte 4, wr_data=0x04030201, wr_adr=0x010, word_count=1.
REQ-033 Flush pad: bytes 0xAA,0xBB then flush -> wr_data=0x0000BBAA. A second flush with byte_cnt=0 pushes nothing.
REQ-034 Back-pressure: mem_ack=0, stream 20 bytes -> waiting=1 after 16 bytes (4 words); bytes 17..20 are not accepted until mem_ack=1, then all 5 words are written in order at consecutive addresses.
REQ-035 Wrap: base_adr=0x3FF, 2 words -> wr_adr 0x3FF then 0x000.
REQ-036 Ignored load: base_load while busy=1 -> wr_adr unchanged. Reset asserted during W_REQ with mem_ack=0 -> wr_en=0, busy=0, word_count=0 after the edge.
REQ-037 Simultaneous byte+flush: byte_cnt=3, in_byte=0x55 and flush together -> exactly one word pushed (0x55 in bits 31:24) and byte_cnt=0.

Source files
------------

// File: rtl/code_writer.sv
// code_writer: packs emitted ARM code bytes little-endian into 32-bit words,
// queues them in a small FIFO and writes them to code memory at consecutive
// word addresses.
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous, active-low
//   in_valid    in_byte carries an emitted code byte
//   in_byte     code byte, lane order 0..3 within a word
//   flush       close the current partial word (zero-padded)
//   base_load   load base_adr into the write address (only while idle)
//   base_adr    new start word address
//   mem_ack     code memory accepts wr_data this cycle
//   wr_en       write request to code memory
//   wr_adr      word address of the current write
//   wr_data     packed word being written (0 when no request)
//   waiting     FIFO full; bytes and flush are refused while high
//   busy        partial word held or FIFO non-empty
//   word_count  words written since reset, wraps at 2^16
//
// Write FSM
//   state  | meaning
//   W_IDLE | FIFO empty, no write request
//   W_REQ  | wr_en high, FIFO head presented until mem_ack
module code_writer #(
  parameter int ADR_W = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  input  logic             flush,
  input  logic             base_load,
  input  logic [ADR_W-1:0] base_adr,
  input  logic             mem_ack,
  output logic             wr_en,
  output logic [ADR_W-1:0] wr_adr,
  output logic [31:0]      wr_data,
  output logic             waiting,
  output logic             busy,
  output logic [15:0]      word_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_REQ  = 1'b1;

  logic [0:0]       state, state_next;
  logic [1:0]       byte_cnt, cnt_after;
  logic [31:0]      pack_word, merged;
  logic [31:0]      fifo_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   fifo_cnt, cnt_next;
  logic [ADR_W-1:0] adr_q;
  logic [15:0]      wc_q;
  logic             byte_acc, flush_acc, push, pop;

  assign waiting    = (fifo_cnt == FULL_CNT);
  assign busy       = (byte_cnt != 2'd0) | (fifo_cnt != '0);
  assign wr_en      = (state == W_REQ);
  assign wr_data    = wr_en ? fifo_mem[rd_ptr] : 32'h0;
  assign wr_adr     = adr_q;
  assign word_count = wc_q;

  // Lanes above byte_cnt are always zero in pack_word, so a flushed word
  // is padded with 0x00 without extra masking.
  always_comb begin
    byte_acc  = in_valid & ~waiting;
    flush_acc = flush & ~waiting;
    merged    = pack_word;
    if (byte_acc) begin
      merged[{byte_cnt, 3'b000} +: 8] = in_byte;
    end
    cnt_after = byte_cnt + {1'b0, byte_acc};
    // A byte that completes the word wraps cnt_after to 0, which turns a
    // simultaneous flush into a no-op.
    push = (byte_acc && (byte_cnt == 2'd3)) || (flush_acc && (cnt_after != 2'd0));
    pop  = wr_en & mem_ack;
    case ({push, pop})
      2'b10:   cnt_next = fifo_cnt + (PTR_W+1)'(1);
      2'b01:   cnt_next = fifo_cnt - (PTR_W+1)'(1);
      default: cnt_next = fifo_cnt;
    endcase
    // Entering W_REQ on the push edge presents the word the very next cycle.
    state_next = (cnt_next != '0) ? W_REQ : W_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= W_IDLE;
      byte_cnt  <= 2'd0;
      pack_word <= 32'h0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifo_cnt  <= '0;
      adr_q     <= '0;
      wc_q      <= 16'h0;
    end else begin
      state     <= state_next;
      byte_cnt  <= push ? 2'd0 : cnt_after;
      pack_word <= push ? 32'h0 : merged;
      fifo_cnt  <= cnt_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        wc_q   <= wc_q + 16'd1;
      end
      // busy=0 implies an empty FIFO, so a load never collides with a pop.
      if (base_load && !busy) begin
        adr_q <= base_adr;
      end else if (pop) begin
        adr_q <= adr_q + ADR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= merged;
  end

endmodule

// File: tb/tb_code_writer.sv
module tb_code_writer;
  localparam int ADR_W = 10;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset, in_valid, flush, base_load, mem_ack;
  logic [7:0]       in_byte;
  logic [ADR_W-1:0] base_adr;
  logic             wr_en, waiting, busy;
  logic [ADR_W-1:0] wr_adr;
  logic [31:0]      wr_data;
  logic [15:0]      word_count;

  int n_vec = 0;
  int n_err = 0;

  // reference model: pending bytes, queue of finished words, address, count
  logic [7:0]       m_part [4];
  int               m_pn;
  logic [31:0]      m_q [$];
  logic [ADR_W-1:0] m_adr;
  logic [15:0]      m_wc;

  always #5 clk = ~clk;

  code_writer #(.ADR_W(ADR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
    .flush(flush), .base_load(base_load), .base_adr(base_adr),
    .mem_ack(mem_ack), .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
    .waiting(waiting), .busy(busy), .word_count(word_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_push();
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < m_pn; i++) w = w | (32'(m_part[i]) << (8 * i));
    m_q.push_back(w);
    m_pn = 0;
  endtask

  task automatic model_edge();
    bit full, bsy, pop;
    if (!reset) begin
      m_pn = 0;
      m_q.delete();
      m_adr = '0;
      m_wc = 16'h0;
    end else begin
      full = (m_q.size() == DEPTH);
      bsy  = (m_pn != 0) || (m_q.size() != 0);
      pop  = (m_q.size() != 0) && mem_ack;
      if (pop) void'(m_q.pop_front());
      if (!full) begin
        if (in_valid) begin
          m_part[m_pn] = in_byte;
          m_pn++;
          if (m_pn == 4) model_push();
        end
        if (flush && m_pn != 0) model_push();
      end
      if (base_load && !bsy) m_adr = base_adr;
      else if (pop) m_adr = m_adr + ADR_W'(1);
      if (pop) m_wc = m_wc + 16'd1;
    end
  endtask

  task automatic check_all();
    check_val("waiting", 32'(waiting), 32'(m_q.size() == DEPTH));
    check_val("busy", 32'(busy), 32'((m_pn != 0) || (m_q.size() != 0)));
    check_val("wr_en", 32'(wr_en), 32'(m_q.size() != 0));
    check_val("wr_data", wr_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
    check_val("wr_adr", 32'(wr_adr), 32'(m_adr));
    check_val("word_count", 32'(word_count), 32'(m_wc));
  endtask

  task automatic step(input bit rst_n, input bit v, input logic [7:0] b, input bit f,
                      input bit bl, input logic [ADR_W-1:0] ba, input bit ack);
    reset = rst_n; in_valid = v; in_byte = b; flush = f;
    base_load = bl; base_adr = ba; mem_ack = ack;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input bit ack);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, '0, ack);
  endtask

  task automatic put(input logic [7:0] b, input bit ack);
    step(1'b1, 1'b1, b, 1'b0, 1'b0, '0, ack);
  endtask

  logic [31:0]      gw [$];
  logic [ADR_W-1:0] ga [$];
  int               idx;
  logic [15:0]      wc0;
  bit               acc;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_byte = 8'h00; flush = 1'b0;
    base_load = 1'b0; base_adr = '0; mem_ack = 1'b0;
    m_pn = 0; m_adr = '0; m_wc = 16'h0;

    // reset
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 8'h99, 1'b1, 1'b1, 10'h123, 1'b1);
    check_val("rst_wr_en", 32'(wr_en), 32'h0);
    check_val("rst_adr", 32'(wr_adr), 32'h0);

    // pack four bytes
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'h010, 1'b1);
    put(8'h01, 1'b1); put(8'h02, 1'b1); put(8'h03, 1'b1); put(8'h04, 1'b1);
    check_val("pack_en", 32'(wr_en), 32'h1);
    check_val("pack_data", wr_data, 32'h04030201);
    check_val("pack_adr", 32'(wr_adr), 32'h010);
    idle(1'b1);
    check_val("pack_cnt", 32'(word_count), 32'h1);

    // flush padding and empty flush
    put(8'hAA, 1'b0); put(8'hBB, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, '0, 1'b0);
    check_val("pad_data", wr_data, 32'h0000BBAA);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, '0, 1'b0);
    idle(1'b1);
    check_val("pad_busy", 32'(busy), 32'h0);
    check_val("pad_cnt", 32'(word_count), 32'h2);

    // back-pressure: 20 bytes, memory stalled
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'h100, 1'b0);
    idx = 1;
    for (int t = 0; t < 20; t++) begin
      acc = (m_q.size() != DEPTH);
      put(8'(idx), 1'b0);
      if (acc) idx++;
    end
    check_val("bp_wait", 32'(waiting), 32'h1);
    check_val("bp_held", 32'(idx), 32'd17);
    wc0 = m_wc;
    gw.delete(); ga.delete();
    for (int t = 0; t < 40 && (idx <= 20 || m_q.size() != 0 || m_pn != 0); t++) begin
      if (wr_en) begin gw.push_back(wr_data); ga.push_back(wr_adr); end
      acc = (m_q.size() != DEPTH) && (idx <= 20);
      step(1'b1, idx <= 20, 8'(idx), 1'b0, 1'b0, '0, 1'b1);
      if (acc) idx++;
    end
    check_val("bp_done", 32'(idx), 32'd21);
    check_val("bp_nwords", 32'(gw.size()), 32'd5);
    for (int k = 0; k < 5 && k < gw.size(); k++) begin
      check_val("bp_word", gw[k], {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)});
      check_val("bp_adr", 32'(ga[k]), 32'h100 + 32'(k));
    end
    check_val("bp_count", 32'(word_count), 32'(wc0) + 32'd5);

    // address wrap
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'h3FF, 1'b0);
    for (int i = 1; i <= 8; i++) put(8'(i), 1'b0);
    check_val("wrap_adr0", 32'(wr_adr), 32'h3FF);
    idle(1'b1);
    check_val("wrap_adr1", 32'(wr_adr), 32'h000);
    idle(1'b1);

    // ignored load while busy, then reset during a pending write
    put(8'h77, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'h055, 1'b0);
    check_val("ign_load", 32'(wr_adr), 32'h001);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, '0, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0, 1'b0);
    check_val("rst_mid_en", 32'(wr_en), 32'h0);
    check_val("rst_mid_busy", 32'(busy), 32'h0);
    check_val("rst_mid_cnt", 32'(word_count), 32'h0);

    // byte completing a word together with flush
    put(8'h11, 1'b0); put(8'h22, 1'b0); put(8'h33, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b1, 1'b0, '0, 1'b0);
    check_val("bf_data", wr_data, 32'h55332211);
    step(1'b1, 1'b1, 8'h66, 1'b1, 1'b0, '0, 1'b1);
    check_val("bf_next", wr_data, 32'h00000066);
    idle(1'b1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bit hi_ack;
      hi_ack = ((c / 100) % 2) == 0;
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 9) < 7,
           8'($urandom),
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 9) == 0,
           ADR_W'($urandom),
           hi_ack ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
